accum_sel_param: RTL



---
 rtl/accum_sel_pkg.sv | 14 +
 rtl/accum_sel_operand.sv | 31 +++
 rtl/accum_sel_param.sv | 119 +++++++++++
 3 files changed

// File: rtl/accum_sel_pkg.sv
// Shared encodings for the selective-adder / accumulator engine.
package accum_sel_pkg;

  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,
    OP_ADD  = 2'b01,
    OP_PASS = 2'b10,
    OP_ZERO = 2'b11
  } op_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/accum_sel_operand.sv
// Combinational operand selector: difference, sum, pass-through or zero,
// widened to a signed result that can hold any of them exactly.
module accum_sel_operand
  import accum_sel_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input  logic [DATA_W-1:0]        i_data1,
  input  logic [DATA_W-1:0]        i_data2,
  input  logic [1:0]               i_sel,
  output logic signed [DATA_W+1:0] o_operand
);

  logic signed [DATA_W+1:0] data1Ext;
  logic signed [DATA_W+1:0] data2Ext;

  assign data1Ext = signed'({2'b00, i_data1});
  assign data2Ext = signed'({2'b00, i_data2});

  always_comb begin
    o_operand = '0;
    case (op_e'(i_sel))
      OP_SUB:  o_operand = data1Ext - data2Ext;
      OP_ADD:  o_operand = data1Ext + data2Ext;
      OP_PASS: o_operand = data1Ext;
      OP_ZERO: o_operand = '0;
      default: o_operand = '0;
    endcase
  end

endmodule

// File: rtl/accum_sel_param.sv
// Two-stage accumulate engine: registered operand select, then a wide
// accumulator with wrap/saturate, sticky flags and a registered threshold flag.
module accum_sel_param
  import accum_sel_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int ACC_W  = 6
) (
  input  logic              clock,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [1:0]        i_sel,
  input  logic              i_sat,
  input  logic              i_clear,
  input  logic [ACC_W-1:0]  i_thresh,
  output logic [ACC_W-1:0]  o_data,
  output logic              o_valid,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic              o_thresh
);

  localparam int OP_W  = DATA_W + 2;
  localparam int SUM_W = ACC_W + 2;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  logic signed [OP_W-1:0] opSel;
  logic signed [OP_W-1:0] operand_q, operand_d;
  logic                   s1Valid_q, s1Valid_d;
  logic                   sat_q, sat_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   thresh_q, thresh_d;

  logic [SUM_W-1:0]       operandExt;
  logic [SUM_W-1:0]       sumExt;

  accum_sel_operand #(
    .DATA_W(DATA_W)
  ) u_operand (
    .i_data1  (i_data1),
    .i_data2  (i_data2),
    .i_sel    (i_sel),
    .o_operand(opSel)
  );

  // Two extra bits make the sum exact: MSB is the sign, bit ACC_W flags overflow.
  assign operandExt = {{(SUM_W-OP_W){operand_q[OP_W-1]}}, operand_q};
  assign sumExt     = {2'b00, acc_q} + operandExt;

  always_comb begin
    operand_d = i_valid ? opSel : operand_q;
    sat_d     = i_valid ? i_sat : sat_q;
    s1Valid_d = i_valid;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    valid_d   = 1'b0;

    if (s1Valid_q) begin
      valid_d = 1'b1;
      if (sumExt[SUM_W-1]) begin
        udf_d = 1'b1;
        acc_d = (sat_q == MODE_SAT) ? '0 : sumExt[ACC_W-1:0];
      end else if (sumExt[ACC_W]) begin
        ovf_d = 1'b1;
        acc_d = (sat_q == MODE_SAT) ? ACC_MAX : sumExt[ACC_W-1:0];
      end else begin
        acc_d = sumExt[ACC_W-1:0];
      end
    end

    // Clear overrides both the new sample and the operation already in stage 1.
    if (i_clear) begin
      operand_d = '0;
      sat_d     = MODE_WRAP;
      s1Valid_d = 1'b0;
      acc_d     = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
      valid_d   = 1'b0;
    end

    thresh_d = (acc_d >= i_thresh);
  end

  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      operand_q <= '0;
      sat_q     <= MODE_WRAP;
      s1Valid_q <= 1'b0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      thresh_q  <= 1'b0;
    end else begin
      operand_q <= operand_d;
      sat_q     <= sat_d;
      s1Valid_q <= s1Valid_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      thresh_q  <= thresh_d;
    end
  end

  assign o_data      = acc_q;
  assign o_valid     = valid_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;
  assign o_thresh    = thresh_q;

endmodule
